// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage.
//   - It holds a 16 x 32-bit instruction memory with its own write port.
//   - It keeps a 4-bit PC.
//   - Each RUN cycle it registers the word at pc and the word at pc+1, both
//     feeding the IF/ID register.
//   - Stall holds all fetch state. Redirect retargets the PC and inserts one
//     bubble. Redirect takes priority over stall.
//   - Fetching the word 32'hFFFFFFFF moves the unit to HALT. Only rst leaves
//     HALT.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   start               one-cycle pulse, IDLE -> RUN
//   imem_we/waddr/wdata instruction memory write port (active in every state)
//   stall               hold fetch state
//   redirect/_pc        branch/jump retarget
//   instr               registered mem[pc]
//   nextInstr           registered mem[pc+1]
//   nextPC              registered pc+1
//   pc                  current fetch PC
//   valid               instr/nextInstr/nextPC hold a real fetch
//   halted              unit is in HALT
//
// Optional build macro FETCH_PERF_CNT_EN adds two outputs:
//   fetch_cnt           saturating count of fetches
//   stall_cnt           saturating count of RUN stall cycles
// -----------------------------------------------------------------------------
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        imem_we,
  input  logic [3:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [3:0]  redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] nextInstr,
  output logic [3:0]  nextPC,
  output logic [3:0]  pc,
  output logic        valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ninstr_q, ninstr_d;
  logic [3:0]  npc_q, npc_d;
  logic        valid_q, valid_d;
  logic        fetch_en;

  logic [31:0] mem_q [16];
  logic [3:0]  pc_inc;
  logic [31:0] rd_cur, rd_nxt;

  // 4-bit arithmetic gives the mod-16 wrap for free.
  assign pc_inc = pc_q + 4'd1;

  // Reads sample the array before this edge's write lands. A same-cycle
  // write to the fetched address therefore returns the old word.
  assign rd_cur = mem_q[pc_q];
  assign rd_nxt = mem_q[pc_inc];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ninstr_d = ninstr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    fetch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          // One bubble, then fetching resumes at the new target.
          pc_d     = redirect_pc;
          instr_d  = '0;
          ninstr_d = '0;
          npc_d    = '0;
          valid_d  = 1'b0;
        end else if (!stall) begin
          fetch_en = 1'b1;
          instr_d  = rd_cur;
          ninstr_d = rd_nxt;
          npc_d    = pc_inc;
          valid_d  = 1'b1;
          pc_d     = pc_inc;
          // The halt word is still presented with valid=1 on the next
          // cycle. HALT then clears valid one cycle later.
          if (rd_cur == 32'hFFFF_FFFF) state_d = S_HALT;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      ninstr_q <= '0;
      npc_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ninstr_q <= ninstr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
    end
  end

  // The memory has no reset. Writes complete even during rst.
  always_ff @(posedge clk) begin
    if (imem_we) mem_q[imem_waddr] <= imem_wdata;
  end

  assign instr     = instr_q;
  assign nextInstr = ninstr_q;
  assign nextPC    = npc_q;
  assign pc        = pc_q;
  assign valid     = valid_q;
  assign halted    = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;
  logic        stall_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign stall_hit = (state_q == S_RUN) && stall && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_en)  fetch_cnt_q <= sat_inc16(fetch_cnt_q);
      if (stall_hit) stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit in the default build, without the
//   performance counters. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_we;
  logic [3:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        stall;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic [31:0] instr;
  logic [31:0] nextInstr;
  logic [3:0]  nextPC;
  logic [3:0]  pc;
  logic        valid;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .nextInstr  (nextInstr),
    .nextPC     (nextPC),
    .pc         (pc),
    .valid      (valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ei, input logic [31:0] en,
                         input logic [3:0] enpc, input logic [3:0] epc, input logic ev,
                         input logic eh);
    check({tag, ".instr"},     instr,            ei);
    check({tag, ".nextInstr"}, nextInstr,        en);
    check({tag, ".nextPC"},    {28'd0, nextPC},  {28'd0, enpc});
    check({tag, ".pc"},        {28'd0, pc},      {28'd0, epc});
    check({tag, ".valid"},     {31'd0, valid},   {31'd0, ev});
    check({tag, ".halted"},    {31'd0, halted},  {31'd0, eh});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk_all("reset", 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Load mem[i] = A0000000 + i.
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_waddr = 4'(i); imem_wdata = 32'hA000_0000 + 32'(i);
      step();
    end
    imem_we = 1'b0;
    check("idle.valid", {31'd0, valid}, 32'd0);

    // Start, then sequential fetch.
    start = 1'b1; step(); start = 1'b0;
    check("start.valid", {31'd0, valid}, 32'd0);
    check("start.pc", {28'd0, pc}, 32'd0);
    step();
    chk_all("fetch1", 32'hA000_0000, 32'hA000_0001, 4'h1, 4'h1, 1'b1, 1'b0);
    step();
    chk_all("fetch2", 32'hA000_0001, 32'hA000_0002, 4'h2, 4'h2, 1'b1, 1'b0);
    step(); step(); step();
    chk_all("fetch5", 32'hA000_0004, 32'hA000_0005, 4'h5, 4'h5, 1'b1, 1'b0);

    // Stall at pc=5 for three cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'hA000_0004, 32'hA000_0005, 4'h5, 4'h5, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_all("resume", 32'hA000_0005, 32'hA000_0006, 4'h6, 4'h6, 1'b1, 1'b0);

    // Redirect with a simultaneous stall: redirect wins.
    redirect = 1'b1; redirect_pc = 4'hC; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk_all("redir", 32'h0, 32'h0, 4'h0, 4'hC, 1'b0, 1'b0);
    step();
    chk_all("redir_fetch", 32'hA000_000C, 32'hA000_000D, 4'hD, 4'hD, 1'b1, 1'b0);

    // Write mem[15] and mem[0] while running, then wrap.
    imem_we = 1'b1; imem_waddr = 4'hF; imem_wdata = 32'h1111_1111;
    step();                                    // fetches pc=D
    imem_waddr = 4'h0; imem_wdata = 32'h2222_2222;
    step();                                    // fetches pc=E
    chk_all("pre_wrap", 32'hA000_000E, 32'h1111_1111, 4'hF, 4'hF, 1'b1, 1'b0);
    // Same-cycle write to the fetched address returns old data.
    imem_waddr = 4'hF; imem_wdata = 32'h3333_3333;
    step();
    chk_all("wrap", 32'h1111_1111, 32'h2222_2222, 4'h0, 4'h0, 1'b1, 1'b0);

    // Plant the halt word at mem[2] while fetching pc=0.
    imem_waddr = 4'h2; imem_wdata = 32'hFFFF_FFFF;
    step();
    imem_we = 1'b0;
    chk_all("fetch0", 32'h2222_2222, 32'hA000_0001, 4'h1, 4'h1, 1'b1, 1'b0);
    step();
    chk_all("pre_halt", 32'hA000_0001, 32'hFFFF_FFFF, 4'h2, 4'h2, 1'b1, 1'b0);
    step();
    chk_all("halt_word", 32'hFFFF_FFFF, 32'hA000_0003, 4'h3, 4'h3, 1'b1, 1'b1);
    start = 1'b1; redirect = 1'b1; redirect_pc = 4'h8;
    step();
    chk_all("halted1", 32'hFFFF_FFFF, 32'hA000_0003, 4'h3, 4'h3, 1'b0, 1'b1);
    step();
    chk_all("halted2", 32'hFFFF_FFFF, 32'hA000_0003, 4'h3, 4'h3, 1'b0, 1'b1);
    start = 1'b0; redirect = 1'b0;

    // Reset out of HALT. Memory survives.
    rst = 1'b1; step(); rst = 1'b0;
    chk_all("rst_halt", 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    imem_we = 1'b1; imem_waddr = 4'h2; imem_wdata = 32'hA000_0002;
    step();
    imem_we = 1'b0;
    check("idle_hold.pc", {28'd0, pc}, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check("mem_kept", instr, 32'h2222_2222);
    for (int i = 0; i < 6; i++) step();
    chk_all("at_pc7", 32'hA000_0006, 32'hA000_0007, 4'h7, 4'h7, 1'b1, 1'b0);

    // Reset mid-RUN with a simultaneous write to addr 7.
    rst = 1'b1; imem_we = 1'b1; imem_waddr = 4'h7; imem_wdata = 32'h7777_7777;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 4'h9;
    step();
    rst = 1'b0; imem_we = 1'b0; stall = 1'b0; redirect = 1'b0;
    chk_all("rst_run", 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    check("rst_idle.valid", {31'd0, valid}, 32'd0);
    check("rst_idle.pc", {28'd0, pc}, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    redirect = 1'b1; redirect_pc = 4'h7; step(); redirect = 1'b0;
    check("redir7.pc", {28'd0, pc}, 32'd7);
    step();
    chk_all("mem7_new", 32'h7777_7777, 32'hA000_0008, 4'h8, 4'h8, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
